// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: turns per-cycle pixel coordinates and sync from the VGA
// timing FSMs into framebuffer read requests, then drives registered RGB,
// blanking and sync to the DAC. Sync and valid are delayed by the memory
// read latency so colour lines up with the coordinate that produced it.
// Input-to-output latency is READ_LATENCY+2 cycles.
//
// Optional build macro VGA_PIXEL_BORDER_EN: when defined, pixels on the
// outermost row/column of the active area are forced to white. The read is
// still issued for them, so framebuffer addressing is identical either way.
module vga_pixel_pipe #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ADDR_W       = 19,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_hs,
  input  logic              vga_vs,
  input  logic              addr_x_valid,
  input  logic              addr_y_valid,
  input  logic [9:0]        addr_x,
  input  logic [9:0]        addr_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_hs,
  output logic              out_vs,
  output logic              out_blank_n,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b
);

  // One stage per memory latency cycle plus the request register itself,
  // so the tail of the delay line coincides with mem_rdata being valid.
  localparam int DEPTH = READ_LATENCY + 1;

  // Address of the final visible pixel; the counter wraps after it.
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  // ---------------------------------------------------------------------
  // Stage 0: read request
  // ---------------------------------------------------------------------
  logic              pix_valid;
  logic              frame_origin;
  logic [ADDR_W-1:0] base;

  logic              mem_rd_q,   mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] pix_cnt_q,  pix_cnt_d;

  assign pix_valid    = addr_x_valid & addr_y_valid;
  assign frame_origin = (addr_x == 10'd0) && (addr_y == 10'd0);

  // Linear address comes from a running counter instead of y*H_ACTIVE+x;
  // the (0,0) coordinate forces it back to zero so any glitch heals by the
  // next frame. Vsync low clears the counter and wins over a valid pixel.
  always_comb begin
    base       = frame_origin ? '0 : pix_cnt_q;
    mem_rd_d   = pix_valid;
    mem_addr_d = mem_addr_q;
    pix_cnt_d  = pix_cnt_q;
    if (pix_valid) begin
      mem_addr_d = base;
      pix_cnt_d  = (base == LAST_PIX) ? '0 : base + ADDR_W'(1);
    end
    if (!vga_vs) begin
      pix_cnt_d = '0;
    end
  end

  // Request registers and pixel counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      pix_cnt_q  <= '0;
    end else begin
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      pix_cnt_q  <= pix_cnt_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

  // ---------------------------------------------------------------------
  // Delay line: sync and valid follow the read through the memory
  // ---------------------------------------------------------------------
  logic [DEPTH-1:0] hs_dly_q,  hs_dly_d;
  logic [DEPTH-1:0] vs_dly_q,  vs_dly_d;
  logic [DEPTH-1:0] vld_dly_q, vld_dly_d;

  // Bit 0 takes the live input; each higher bit is one cycle older.
  always_comb begin
    hs_dly_d  = {hs_dly_q[DEPTH-2:0],  vga_hs};
    vs_dly_d  = {vs_dly_q[DEPTH-2:0],  vga_vs};
    vld_dly_d = {vld_dly_q[DEPTH-2:0], pix_valid};
  end

  // Shift registers idle at "sync inactive, pixel invalid".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_dly_q  <= '1;
      vs_dly_q  <= '1;
      vld_dly_q <= '0;
    end else begin
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
      vld_dly_q <= vld_dly_d;
    end
  end

`ifdef VGA_PIXEL_BORDER_EN
  logic             border_pix;
  logic [DEPTH-1:0] brd_dly_q, brd_dly_d;

  assign border_pix = (addr_x == 10'(H_ACTIVE - 1)) || (addr_x == 10'd0) ||
                      (addr_y == 10'(V_ACTIVE - 1)) || (addr_y == 10'd0);

  // Border flag rides alongside valid so it meets the returning data.
  always_comb begin
    brd_dly_d = {brd_dly_q[DEPTH-2:0], border_pix};
  end

  // Border flag delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brd_dly_q <= '0;
    end else begin
      brd_dly_q <= brd_dly_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Stage N: colour expansion and output registers
  // ---------------------------------------------------------------------
  logic       out_hs_q,      out_hs_d;
  logic       out_vs_q,      out_vs_d;
  logic       out_blank_n_q, out_blank_n_d;
  logic [7:0] out_r_q,       out_r_d;
  logic [7:0] out_g_q,       out_g_d;
  logic [7:0] out_b_q,       out_b_d;

  // RGB332 widened by repeating each field's MSBs so full-scale codes map
  // to 8'hFF; colour is forced to black whenever the delayed pixel is not
  // active, so whatever the memory returns during blanking is discarded.
  always_comb begin
    out_hs_d      = hs_dly_q[DEPTH-1];
    out_vs_d      = vs_dly_q[DEPTH-1];
    out_blank_n_d = vld_dly_q[DEPTH-1];
    out_r_d       = 8'h00;
    out_g_d       = 8'h00;
    out_b_d       = 8'h00;
    if (vld_dly_q[DEPTH-1]) begin
`ifdef VGA_PIXEL_BORDER_EN
      if (brd_dly_q[DEPTH-1]) begin
        out_r_d = 8'hFF;
        out_g_d = 8'hFF;
        out_b_d = 8'hFF;
      end else begin
        out_r_d = {mem_rdata[7:5], mem_rdata[7:5], mem_rdata[7:6]};
        out_g_d = {mem_rdata[4:2], mem_rdata[4:2], mem_rdata[4:3]};
        out_b_d = {mem_rdata[1:0], mem_rdata[1:0], mem_rdata[1:0], mem_rdata[1:0]};
      end
`else
      out_r_d = {mem_rdata[7:5], mem_rdata[7:5], mem_rdata[7:6]};
      out_g_d = {mem_rdata[4:2], mem_rdata[4:2], mem_rdata[4:3]};
      out_b_d = {mem_rdata[1:0], mem_rdata[1:0], mem_rdata[1:0], mem_rdata[1:0]};
`endif
    end
  end

  // DAC-facing registers; reset drives sync inactive and colour black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_hs_q      <= 1'b1;
      out_vs_q      <= 1'b1;
      out_blank_n_q <= 1'b0;
      out_r_q       <= 8'h00;
      out_g_q       <= 8'h00;
      out_b_q       <= 8'h00;
    end else begin
      out_hs_q      <= out_hs_d;
      out_vs_q      <= out_vs_d;
      out_blank_n_q <= out_blank_n_d;
      out_r_q       <= out_r_d;
      out_g_q       <= out_g_d;
      out_b_q       <= out_b_d;
    end
  end

  assign out_hs      = out_hs_q;
  assign out_vs      = out_vs_q;
  assign out_blank_n = out_blank_n_q;
  assign out_r       = out_r_q;
  assign out_g       = out_g_q;
  assign out_b       = out_b_q;

endmodule
